div_4_seq: RTL and testbench
============================

Name: div_4_seq

Overview:
Sequential unsigned restoring divider. It is the inverse-direction companion of the team's 4-bit carry look-ahead adder.
- Computes Q = A / B and R = A % B, one quotient bit per clock.
- Each step is a trial subtraction done as addition of the two's complement: P + ~B + 1, carry-in forced to 1.
- Sits beside the combinational adder in the lab arithmetic library. Driven by a start/busy/done handshake from a test bench or controller.

Parameters:
WIDTH, 4, operand width of A, B, Q and R (supported range 2..8).

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request a division; sampled only in IDLE
A  input  WIDTH  dividend; captured on the edge that accepts START
B  input  WIDTH  divisor; captured on the edge that accepts START
BUSY  output  1  high while an operation is in progress (states CALC and DONE)
DONE  output  1  one-cycle pulse; Q, R and DZ valid from this cycle on
Q  output  WIDTH  quotient
R  output  WIDTH  remainder
DZ  output  1  divide-by-zero flag

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high, and takes priority over everything.
- Reset values: state=IDLE, BUSY=0, DONE=0, Q=0, R=0, DZ=0, internal count=0, partial remainder=0.
- States:
  - IDLE: BUSY=0. START=1 at an edge latches A and B, clears DZ, loads the quotient shift register with A, sets P=0 and count=WIDTH.
    - B!=0 -> next state CALC.
    - B==0 -> next state DONE with Q=all ones, R=A, DZ=1.
  - CALC, one step per edge:
    - Shift {P, Qsr} left by 1 (P is WIDTH+1 bits).
    - T = P_shifted + ~{0,B} + 1, computed over WIDTH+1 bits.
    - If the carry-out is 1 (no borrow): P=T, new quotient LSB=1. Otherwise P is restored (keeps P_shifted), LSB=0.
    - count decrements each step. When count reaches 0 after the final step, move to DONE.
  - DONE: DONE=1 for exactly this one cycle. Q=Qsr, R=P[WIDTH-1:0]. Next state is IDLE unconditionally.
- Latency:
  - B!=0: START accepted at edge k -> DONE high in the cycle after edge k+WIDTH+1. For WIDTH=4, DONE follows edge k+5.
  - B==0: DONE high in the cycle after edge k+1.
- Output hold: Q, R and DZ hold their values after DONE until the next START is accepted. During CALC, Q and R keep the previous result; they do not show intermediate values.
- START while BUSY=1 (CALC or DONE): ignored. It is not queued.
- A and B changing during CALC: no effect, because the operands were latched at acceptance.
- RST asserted mid-operation: abort on that edge and apply all reset values. No DONE pulse is produced.
- Boundary results (WIDTH=4):
  - A<B -> Q=0, R=A.
  - A=B -> Q=1, R=0.
  - B=1 -> Q=A, R=0.
  - A=0, B!=0 -> Q=0, R=0.
- Width rule: the trial subtraction always uses WIDTH+1 bits so that a shifted remainder up to 2*B-1 never overflows.

Decomposition:
- Shared package/include:
  - state encoding constants: ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - DIV_W default width constant.
- Sub-module sub_cla_n: combinational WIDTH+1-bit subtractor.
  - Computes A + ~B + 1 with carry look-ahead generate/propagate.
  - Outputs the difference and CO; the borrow is !CO.
- FSM, counter and shift registers live in div_4_seq.

Test Plan:
- RST 2 cycles, then START with A=13, B=3 -> DONE pulse 5 edges after acceptance, Q=4, R=1, DZ=0. BUSY high for exactly 5 cycles.
- A=15, B=1 -> Q=15, R=0. Then A=6, B=9 -> Q=0, R=6. Then A=0, B=5 -> Q=0, R=0.
- A=9, B=0 -> DONE 1 edge after acceptance, Q=4'b1111, R=9, DZ=1. Next division A=8, B=2 -> DZ=0, Q=4, R=0.
- Accept START (A=14, B=4), pulse START again with A=1, B=1 at edges +1 and +4 -> single DONE, result Q=3, R=2. Previous Q/R held during CALC.
- Accept START (A=11, B=2), assert RST at edge +2 -> BUSY=0, Q=0, R=0, no DONE pulse. A fresh START afterwards gives Q=5, R=1.
- Exhaustive sweep of all 256 (A,B) pairs:
  - B!=0: Q==A/B and R==A%B, else error count increments.
  - B==0: DZ=1.
  - Measure max START-to-DONE cycles and print with $display; expected 5 for WIDTH=4.

Source files
------------

// File: rtl/div_4_seq_pkg.sv
// div_4_seq_pkg: shared state encoding and default width for the sequential divider
package div_4_seq_pkg;
  localparam int DIV_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_4_seq_sub.sv
// sub_cla_n: combinational a + ~b + 1 using carry look-ahead generate/propagate
module sub_cla_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d,
  output logic         co
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  assign g = a & ~b;
  assign p = a ^ ~b;
  always_comb begin
    c = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      logic t;
      logic pr;
      t = g[i];
      pr = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t = t | (pr & g[j]);
        pr = pr & p[j];
      end
      c[i+1] = t | pr;
    end
  end
  assign d  = p ^ c[N-1:0];
  assign co = c[N];
endmodule

// File: rtl/div_4_seq.sv
// div_4_seq: unsigned restoring divider producing one quotient bit per clock
module div_4_seq
  import div_4_seq_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   ps;
  logic [WIDTH:0]   diff;
  logic             co;
  logic             bz;
  assign ps = {p_q[WIDTH-1:0], qsr_q[WIDTH-1]};
  assign bz = B == '0;
  sub_cla_n #(.N(WIDTH + 1)) u_sub (
    .a  (ps),
    .b  ({1'b0, b_q}),
    .d  (diff),
    .co (co)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qsr_d   = qsr_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (START) begin
        b_d     = B;
        dz_d    = bz;
        qsr_d   = bz ? '1 : A;
        p_d     = bz ? {1'b0, A} : '0;
        cnt_d   = CW'(WIDTH);
        state_d = bz ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        p_d     = co ? diff : ps;
        qsr_d   = {qsr_q[WIDTH-2:0], co};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? ST_DONE : ST_CALC;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        q_d     = qsr_q;
        r_d     = p_q[WIDTH-1:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      qsr_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qsr_q   <= qsr_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end
  assign BUSY = state_q == ST_CALC || state_q == ST_DONE;
  assign DONE = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
endmodule

// File: tb/tb_div_4_seq.sv
// tb_div_4_seq: scoreboard bench for the sequential divider with directed vectors and a full sweep
module tb_div_4_seq;
  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;
  logic       CLK;
  logic       RST;
  logic       START;
  logic [3:0] A;
  logic [3:0] B;
  logic       BUSY;
  logic       DONE;
  logic [3:0] Q;
  logic [3:0] R;
  logic       DZ;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  div_4_seq #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DZ    (DZ)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (DONE) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done Q=%0d R=%0d DZ=%0d", Q, R, DZ);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Q !== e.q || R !== e.r || DZ !== e.dz) begin
          errors++;
          $display("FAIL result got Q=%0d R=%0d DZ=%0d want Q=%0d R=%0d DZ=%0d",
                   Q, R, DZ, e.q, e.r, e.dz);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] q, input logic [3:0] r, input logic dz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = dz;
    sb.push_back(e);
  endtask
  task automatic wait_done(output int lat, output int busy);
    lat = 0;
    busy = int'(BUSY);
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
      busy += int'(BUSY);
    end
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no DONE within %0d cycles", lat);
    end
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                     input logic [3:0] r, input logic dz, output int lat, output int busy);
    @(negedge CLK);
    A = a;
    B = b;
    START = 1'b1;
    push(q, r, dz);
    @(negedge CLK);
    START = 1'b0;
    wait_done(lat, busy);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    int busy;
    int max_lat;
    RST = 1'b1;
    START = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_q", int'(Q), 0);
    chk("rst_r", int'(R), 0);
    chk("rst_dz", int'(DZ), 0);
    run(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, lat, busy);
    chk("lat_13_3", lat, 5);
    chk("busy_13_3", busy, 5);
    run(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, lat, busy);
    run(4'd6, 4'd9, 4'd0, 4'd6, 1'b0, lat, busy);
    run(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, lat, busy);
    run(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, lat, busy);
    chk("lat_dz", lat, 1);
    chk("busy_dz", busy, 1);
    run(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, lat, busy);
    chk("lat_8_2", lat, 5);
    @(negedge CLK);
    A = 4'd14;
    B = 4'd4;
    START = 1'b1;
    push(4'd3, 4'd2, 1'b0);
    @(negedge CLK);
    A = 4'd1;
    B = 4'd1;
    chk("hold_q_calc0", int'(Q), 4);
    chk("hold_r_calc0", int'(R), 0);
    @(negedge CLK);
    START = 1'b0;
    chk("busy_ign", int'(BUSY), 1);
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("hold_q_calc3", int'(Q), 4);
    chk("done_early", int'(DONE), 0);
    wait_done(lat, busy);
    chk("lat_ign", lat, 1);
    repeat (8) @(negedge CLK);
    chk("idle_after_ign", int'(BUSY), 0);
    @(negedge CLK);
    A = 4'd11;
    B = 4'd2;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_q", int'(Q), 0);
    chk("abort_r", int'(R), 0);
    chk("abort_done", int'(DONE), 0);
    repeat (8) @(negedge CLK);
    run(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, lat, busy);
    max_lat = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] av;
        logic [3:0] bv;
        av = 4'(a);
        bv = 4'(b);
        run(av, bv, b == 0 ? 4'hf : 4'(a / b), b == 0 ? av : 4'(a % b), b == 0, lat, busy);
        chk("sweep_lat", lat, b == 0 ? 1 : 5);
        if (lat > max_lat) max_lat = lat;
      end
    end
    $display("max START-to-DONE cycles %0d", max_lat);
    chk("max_lat", max_lat, 5);
    repeat (4) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
